// File: rtl/candy_avb_irq_pkg.sv
// candy_avb_irq_pkg
// Shared constants for the Avalon-MM interrupt aggregator: data-path width,
// priority index width, position of the valid flag in the HIGHEST register,
// and the word-address map of the slave.
package candy_avb_irq_pkg;

  localparam int DATA_W            = 16;
  localparam int IDX_W             = 4;
  localparam int HIGHEST_VALID_BIT = 15;

  typedef enum logic [2:0] {
    ADDR_STATUS   = 3'd0,
    ADDR_MASK     = 3'd1,
    ADDR_EDGE_SEL = 3'd2,
    ADDR_ACTIVE   = 3'd3,
    ADDR_HIGHEST  = 3'd4,
    ADDR_COUNT    = 3'd5
  } addr_e;

endpackage

// File: rtl/candy_avb_irq_prio_enc.sv
// candy_avb_irq_prio_enc
// Combinational lowest-index-first priority encoder.
// Ports:
//   active_i  in   DATA_W  vector of active (pending & enabled) sources
//   valid_o   out  1       any bit of active_i set
//   idx_o     out  IDX_W   index of the lowest set bit (0 when none set)
module candy_avb_irq_prio_enc
  import candy_avb_irq_pkg::*;
(
  input  logic [DATA_W-1:0] active_i,
  output logic              valid_o,
  output logic [IDX_W-1:0]  idx_o
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    valid_o = |active_i;
    idx_o   = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (active_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/candy_avb_irq_aggregator.sv
// candy_avb_irq_aggregator
// Avalon-MM slave collecting up to 16 interrupt sources into one CPU irq.
// Per-source mask and edge/level selection, W1C pending register and a
// registered "highest pending" readback for single-read ISR dispatch.
// Optional feature macro CANDY_AVB_IRQ_COUNT_EN adds a saturating counter of
// irq 0->1 transitions at word address 5.
// Ports:
//   clk         in   1        system clock
//   reset_n     in   1        asynchronous active-low reset
//   address     in   3        word address
//   chipselect  in   1        slave select
//   write_n     in   1        active-low write strobe
//   writedata   in   16       write data
//   irq_in      in   NUM_IRQ  source interrupts, synchronous, active-high
//   readdata    out  16       registered read data (1-cycle latency)
//   irq         out  1        registered aggregated interrupt
module candy_avb_irq_aggregator
  import candy_avb_irq_pkg::*;
#(
  parameter int                NUM_IRQ      = 8,
  parameter logic [DATA_W-1:0] EDGE_DEFAULT = 16'h0000,
  parameter logic [DATA_W-1:0] MASK_DEFAULT = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [DATA_W-1:0]  writedata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [DATA_W-1:0]  readdata,
  output logic               irq
);

  // Bits at or above NUM_IRQ are tied to zero in every register.
  localparam logic [DATA_W-1:0] VALID_BITS = DATA_W'((17'h1 << NUM_IRQ) - 17'h1);

  logic [DATA_W-1:0] pending_q, pending_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] edge_sel_q, edge_sel_d;
  logic [DATA_W-1:0] irq_in_d_q;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              irq_q, irq_d;
  logic              armed_q;

  logic [DATA_W-1:0] irq_in_ext, rise, w1c, edge_chg, edge_next, active;
  logic              wr_en, hi_valid;
  logic [IDX_W-1:0]  hi_idx;

  assign irq_in_ext = DATA_W'(irq_in);
  assign wr_en      = chipselect & ~write_n;

  // armed_q is low for the first cycle after reset so an input already high
  // at release is not mistaken for a rising edge.
  assign rise = irq_in_ext & ~irq_in_d_q & {DATA_W{armed_q}};
  assign w1c  = (wr_en && address == ADDR_STATUS) ? writedata : '0;

  always_comb begin
    mask_d     = mask_q;
    edge_sel_d = edge_sel_q;
    if (wr_en && address == ADDR_MASK)     mask_d     = writedata & VALID_BITS;
    if (wr_en && address == ADDR_EDGE_SEL) edge_sel_d = writedata & VALID_BITS;
    edge_chg = edge_sel_d ^ edge_sel_q;
    // Edge bits: a rise beats a coincident W1C. Level bits follow the input.
    edge_next = rise | (pending_q & ~w1c);
    pending_d = (edge_sel_q & edge_next) | (~edge_sel_q & irq_in_ext);
    // A mode change discards that bit's pending state.
    pending_d = pending_d & ~edge_chg & VALID_BITS;
  end

  assign active = pending_q & mask_q;
  assign irq_d  = |active;

  candy_avb_irq_prio_enc u_prio_enc (
    .active_i (active),
    .valid_o  (hi_valid),
    .idx_o    (hi_idx)
  );

`ifdef CANDY_AVB_IRQ_COUNT_EN
  logic [DATA_W-1:0] count_q, count_d;
  logic              irq_rise;

  assign irq_rise = irq_d & ~irq_q;

  always_comb begin
    count_d = count_q;
    if (wr_en && address == ADDR_COUNT) begin
      count_d = irq_rise ? DATA_W'(1) : '0;
    end else if (irq_rise && count_q != '1) begin
      count_d = count_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end
`endif

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_STATUS:   readdata_d = pending_q;
      ADDR_MASK:     readdata_d = mask_q;
      ADDR_EDGE_SEL: readdata_d = edge_sel_q;
      ADDR_ACTIVE:   readdata_d = active;
      ADDR_HIGHEST: begin
        readdata_d[HIGHEST_VALID_BIT] = hi_valid;
        readdata_d[IDX_W-1:0]         = hi_idx;
      end
`ifdef CANDY_AVB_IRQ_COUNT_EN
      ADDR_COUNT:    readdata_d = count_q;
`endif
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      mask_q     <= MASK_DEFAULT & VALID_BITS;
      edge_sel_q <= EDGE_DEFAULT & VALID_BITS;
      irq_in_d_q <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      irq_in_d_q <= irq_in_ext;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      armed_q    <= 1'b1;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
